// File: rtl/reaction_timer.sv
// Reaction-time measurement stage: counts milliseconds while go is high,
// latches the result on the falling edge of go and tracks the best time.
module reaction_timer #(
  parameter int unsigned TICK_DIV = 50000,
  parameter int unsigned MAX_MS   = 9999
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        go,
  input  logic        capture,
  input  logic        clear_best,
  output logic [15:0] elapsed_ms,
  output logic [15:0] rt_ms,
  output logic        rt_valid,
  output logic [15:0] best_ms,
  output logic        timeout,
  output logic        busy
);

  localparam int unsigned   PW       = $clog2(TICK_DIV);
  localparam logic [PW-1:0] PRE_LAST = PW'(TICK_DIV - 1);
  localparam logic [15:0]   MS_MAX   = 16'(MAX_MS);

  typedef enum logic {IDLE, RUN} state_t;

  state_t        state, state_next;
  logic          go_q;
  logic [PW-1:0] pre;
  logic [15:0]   ms_cnt;
  logic          rise, fall;

  assign rise       = go & ~go_q;
  assign fall       = ~go & go_q;
  assign elapsed_ms = ms_cnt;

  always_ff @(posedge clk) begin
    if (!reset) state <= IDLE;
    else        state <= state_next;
  end

  always_comb begin
    state_next = state;
    case (state)
      IDLE: if (rise) state_next = RUN;
      RUN:  if (!go)  state_next = IDLE;
    endcase
  end

  always_comb begin
    busy = (state == RUN);
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      go_q     <= 1'b0;
      pre      <= '0;
      ms_cnt   <= '0;
      rt_ms    <= '0;
      rt_valid <= 1'b0;
      timeout  <= 1'b0;
      best_ms  <= '1;
    end else begin
      go_q     <= go;
      rt_valid <= 1'b0;
      case (state)
        IDLE: begin
          // The rise cycle itself is the first counted cycle, hence pre starts at 1.
          if (rise) begin
            pre     <= PW'(1);
            ms_cnt  <= '0;
            timeout <= 1'b0;
          end
        end
        RUN: begin
          if (go) begin
            if (pre == PRE_LAST) begin
              pre <= '0;
              if (ms_cnt < MS_MAX) begin
                ms_cnt <= ms_cnt + 16'd1;
                if (ms_cnt + 16'd1 == MS_MAX) timeout <= 1'b1;
              end else begin
                timeout <= 1'b1;
              end
            end else begin
              pre <= pre + 1'b1;
            end
          end else if (fall && capture) begin
            rt_ms    <= ms_cnt;
            rt_valid <= 1'b1;
            if (!timeout && ms_cnt < best_ms) best_ms <= ms_cnt;
          end
        end
      endcase
      // Placed last so a clear overrides a same-cycle best update.
      if (clear_best) best_ms <= '1;
    end
  end

endmodule

// File: tb/tb_reaction_timer.sv
// Scoreboard bench for reaction_timer with TICK_DIV=4, MAX_MS=20.
module tb_reaction_timer;

  logic        clk = 1'b0;
  logic        reset, go, capture, clear_best;
  logic [15:0] elapsed_ms, rt_ms, best_ms;
  logic        rt_valid, timeout, busy;

  int errors = 0;
  int checks = 0;

  typedef struct {
    logic [15:0] rt;
    logic [15:0] best;
  } exp_t;
  exp_t sb[$];

  reaction_timer #(.TICK_DIV(4), .MAX_MS(20)) dut (
    .clk(clk), .reset(reset), .go(go), .capture(capture),
    .clear_best(clear_best), .elapsed_ms(elapsed_ms), .rt_ms(rt_ms),
    .rt_valid(rt_valid), .best_ms(best_ms), .timeout(timeout), .busy(busy)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  // go high for n sampled cycles, then low; returns one cycle after the fall edge.
  task automatic run(input int n, input logic cap, input logic clr);
    go      = 1'b1;
    capture = cap;
    tick(n);
    check("busy_in_run", busy, 1'b1);
    go         = 1'b0;
    clear_best = clr;
    tick(1);
    clear_best = 1'b0;
    check("busy_after_fall", busy, 1'b0);
  endtask

  initial begin
    fork
      begin : monitor
        logic prev_valid;
        exp_t e;
        prev_valid = 1'b0;
        forever begin
          @(negedge clk);
          if (rt_valid) begin
            if (prev_valid) check("rt_valid_one_cycle", 1'b1, 1'b0);
            if (sb.size() == 0) begin
              check("unexpected_rt_valid", rt_ms, 16'hDEAD);
            end else begin
              e = sb.pop_front();
              check("rt_ms", rt_ms, e.rt);
              check("best_ms", best_ms, e.best);
            end
          end
          prev_valid = rt_valid;
        end
      end
    join_none

    reset = 1'b0; go = 1'b0; capture = 1'b1; clear_best = 1'b0;
    tick(3);
    reset = 1'b1;
    tick(1);
    check("rst_elapsed", elapsed_ms, 16'd0);
    check("rst_rt_ms", rt_ms, 16'd0);
    check("rst_rt_valid", rt_valid, 1'b0);
    check("rst_best", best_ms, 16'hFFFF);
    check("rst_timeout", timeout, 1'b0);
    check("rst_busy", busy, 1'b0);

    sb.push_back('{16'd10, 16'd10}); run(40, 1'b1, 1'b0); tick(2);
    sb.push_back('{16'd6,  16'd6});  run(26, 1'b1, 1'b0); tick(2);
    sb.push_back('{16'd7,  16'd6});  run(30, 1'b1, 1'b0); tick(2);

    // Timeout: 20 ms reached on the 80th sampled cycle.
    go = 1'b1; capture = 1'b1;
    tick(79);
    check("to_elapsed_79", elapsed_ms, 16'd19);
    check("to_flag_79", timeout, 1'b0);
    tick(1);
    check("to_elapsed_80", elapsed_ms, 16'd20);
    check("to_flag_80", timeout, 1'b1);
    tick(20);
    check("to_elapsed_sat", elapsed_ms, 16'd20);
    check("to_flag_hold", timeout, 1'b1);
    sb.push_back('{16'd20, 16'd6});
    go = 1'b0;
    tick(3);

    // Abort: no scoreboard entry, so any rt_valid is flagged.
    run(12, 1'b0, 1'b0);
    tick(2);
    check("abort_elapsed", elapsed_ms, 16'd3);
    check("abort_rt_ms", rt_ms, 16'd20);
    check("abort_best", best_ms, 16'd6);
    check("abort_timeout", timeout, 1'b0);

    sb.push_back('{16'd2, 16'hFFFF}); run(8, 1'b1, 1'b1); tick(2);
    check("clear_best_hold", best_ms, 16'hFFFF);

    // Back-to-back: second rise lands in the rt_valid cycle.
    sb.push_back('{16'd3, 16'd3}); run(12, 1'b1, 1'b0);
    sb.push_back('{16'd5, 16'd3}); run(20, 1'b1, 1'b0);
    tick(2);

    // Reset mid-run.
    go = 1'b1;
    tick(20);
    reset = 1'b0;
    tick(1);
    reset = 1'b1; go = 1'b0;
    tick(2);
    check("mr_elapsed", elapsed_ms, 16'd0);
    check("mr_rt_ms", rt_ms, 16'd0);
    check("mr_rt_valid", rt_valid, 1'b0);
    check("mr_best", best_ms, 16'hFFFF);
    check("mr_timeout", timeout, 1'b0);
    check("mr_busy", busy, 1'b0);

    tick(3);
    check("scoreboard_drained", sb.size(), 0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
